// File: rtl/wave_addr_seq.sv
// Phase-accumulator address sequencer for a sample memory with 1-cycle read latency.
// Plays back in loop or one-pass mode and flushes outstanding reads before returning to idle.
module wave_addr_seq #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned FRAC_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             stop,
  input  logic                             oneshot,
  input  logic [ADDR_WIDTH+FRAC_WIDTH-1:0] step,
  input  logic                             ce,
  output logic [ADDR_WIDTH-1:0]            address,
  input  logic [DATA_WIDTH-1:0]            mem_data,
  output logic [DATA_WIDTH-1:0]            sample,
  output logic                             sample_valid,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned PW = ADDR_WIDTH + FRAC_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e                state_q,     state_d;
  logic [PW-1:0]         phase_q,     phase_d;
  logic [PW-1:0]         step_q,      step_d;
  logic                  mode_q,      mode_d;
  logic                  flush_cnt_q, flush_cnt_d;
  logic                  issue_q,     issue_d;
  logic [DATA_WIDTH-1:0] sample_q,    sample_d;
  logic                  valid_q,     valid_d;
  logic                  busy_q,      busy_d;
  logic                  done_q,      done_d;

  // Phase advance with carry-out; the carry marks the end of a one-pass run.
  logic [PW:0] phase_sum;
  assign phase_sum = {1'b0, phase_q} + {1'b0, step_q};

  // Next-state, phase and issue control.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    step_d      = step_q;
    mode_d      = mode_q;
    flush_cnt_d = flush_cnt_q;
    issue_d     = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          phase_d = '0;
          step_d  = step;
          mode_d  = oneshot;
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d     = FLUSH;
          flush_cnt_d = 1'b0;
        end else if (ce) begin
          issue_d = 1'b1;
          phase_d = phase_sum[PW-1:0];
          if (mode_q && phase_sum[PW]) begin
            state_d     = FLUSH;
            flush_cnt_d = 1'b0;
          end
        end
      end
      FLUSH: begin
        // Two cycles cover the memory latency plus the sample capture stage.
        if (flush_cnt_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          flush_cnt_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sample capture: mem_data is valid the cycle after an issue.
  always_comb begin
    sample_d = sample_q;
    valid_d  = issue_q;
    busy_d   = (state_d != IDLE);
    if (issue_q) begin
      sample_d = mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      step_q      <= '0;
      mode_q      <= 1'b0;
      flush_cnt_q <= 1'b0;
      issue_q     <= 1'b0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      step_q      <= step_d;
      mode_q      <= mode_d;
      flush_cnt_q <= flush_cnt_d;
      issue_q     <= issue_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign address      = phase_q[PW-1 -: ADDR_WIDTH];
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_wave_addr_seq.sv
// Bench for wave_addr_seq: directed vector table, hand-written corner sequences,
// and a randomized run against an event-schedule reference model.
module tb_wave_addr_seq;

  logic        clk;
  logic        rst, start, stop, oneshot, ce;
  logic [15:0] step;
  logic [7:0]  address;
  logic [7:0]  mem_data;
  logic [7:0]  sample;
  logic        sample_valid, busy, done;

  logic [7:0] mem [256];

  int total = 0;
  int bad   = 0;

  wave_addr_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .oneshot      (oneshot),
    .step         (step),
    .ce           (ce),
    .address      (address),
    .mem_data     (mem_data),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous sample memory with one cycle of read latency.
  always @(posedge clk) mem_data <= mem[address];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst, start, stop, oneshot, ce;
    logic [15:0] step;
    logic        chk;
    logic [7:0]  addr, smp;
    logic        vld, bsy, dn;
  } vec_t;

  typedef struct {
    int cyc;
    int val;
  } pend_t;

  // Reference model: playback as a schedule of future events.
  pend_t       eq[$];
  bit          m_run;
  int          m_flush;
  int unsigned m_phase, m_step;
  bit          m_mode;
  int          m_done_cyc;
  int          m_sample;
  bit          exp_v;

  vec_t tbl[12];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    rst = 1'b1; start = 1'b0; stop = 1'b0; oneshot = 1'b0; ce = 1'b0; step = '0;

    // Reset, one-pass playback, start-in-FLUSH and start+stop in IDLE.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h4000, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 8'h40, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 8'hC0, 8'h40, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 8'h00, 8'h80, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 8'h00, 8'hC0, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h00, 8'hC0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0100, 1'b1, 8'h00, 8'hC0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h00, 8'hC0, 1'b0, 1'b0, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].chk) begin
        chk("tbl_addr", 32'(address), 32'(tbl[i].addr));
        chk("tbl_vld",  32'(sample_valid), 32'(tbl[i].vld));
        chk("tbl_smp",  32'(sample), 32'(tbl[i].smp));
        chk("tbl_busy", 32'(busy), 32'(tbl[i].bsy));
        chk("tbl_done", 32'(done), 32'(tbl[i].dn));
      end
      rst = tbl[i].rst; start = tbl[i].start; stop = tbl[i].stop;
      oneshot = tbl[i].oneshot; ce = tbl[i].ce; step = tbl[i].step;
      @(negedge clk);
    end

    // Loop mode across the address wrap, then stop alongside ce.
    start = 1'b1; stop = 1'b0; oneshot = 1'b0; step = 16'h0100; ce = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= 258; k++) begin
      chk("loop_addr", 32'(address), 32'(k % 256));
      chk("loop_busy", 32'(busy), 32'd1);
      if (k >= 2) begin
        chk("loop_vld", 32'(sample_valid), 32'd1);
        chk("loop_smp", 32'(sample), 32'((k - 2) % 256));
      end else begin
        chk("loop_vld", 32'(sample_valid), 32'd0);
      end
      if (k == 258) stop = 1'b1;
      @(negedge clk);
    end
    stop = 1'b0; start = 1'b1;
    chk("stop_vld1",  32'(sample_valid), 32'd1);
    chk("stop_smp1",  32'(sample), 32'd1);
    chk("stop_addr1", 32'(address), 32'd2);
    chk("stop_busy1", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    chk("stop_vld2",  32'(sample_valid), 32'd0);
    chk("stop_busy2", 32'(busy), 32'd1);
    chk("stop_done2", 32'(done), 32'd0);
    @(negedge clk);
    chk("stop_done3", 32'(done), 32'd1);
    chk("stop_busy3", 32'(busy), 32'd0);
    chk("stop_addr3", 32'(address), 32'd2);
    @(negedge clk);
    chk("stop_done4", 32'(done), 32'd0);

    // Fractional step with ce on every third cycle.
    start = 1'b1; step = 16'h0080; oneshot = 1'b0; ce = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < 30; r++) begin
      chk("frac_addr", 32'(address), 32'(((r + 2) / 3) >> 1));
      if (r >= 2 && (r - 2) % 3 == 0) begin
        chk("frac_vld", 32'(sample_valid), 32'd1);
        chk("frac_smp", 32'(sample), 32'(((r - 2) / 3) >> 1));
      end else begin
        chk("frac_vld", 32'(sample_valid), 32'd0);
      end
      ce = (r % 3 == 0);
      @(negedge clk);
    end
    stop = 1'b1; ce = 1'b0;
    @(negedge clk);
    stop = 1'b0;
    chk("frac_busy", 32'(busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("frac_done", 32'(done), 32'd1);
    chk("frac_idle", 32'(busy), 32'd0);

    // Reset in the cycle after an issue discards the pending sample and done.
    start = 1'b1; step = 16'h0100; oneshot = 1'b0; ce = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rmid_addr0", 32'(address), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    chk("rmid_addr1", 32'(address), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("rmid_vld",  32'(sample_valid), 32'd0);
      chk("rmid_done", 32'(done), 32'd0);
      chk("rmid_busy", 32'(busy), 32'd0);
      chk("rmid_addr", 32'(address), 32'd0);
      chk("rmid_smp",  32'(sample), 32'd0);
      @(negedge clk);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_restart0", 32'(address), 32'd0);
    @(negedge clk);
    chk("rst_restart1", 32'(address), 32'd1);
    @(negedge clk);
    chk("rst_restart_vld", 32'(sample_valid), 32'd1);
    chk("rst_restart_smp", 32'(sample), 32'd0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_restart_done", 32'(done), 32'd1);

    // Zero step in one-pass mode: address frozen until stop.
    start = 1'b1; step = 16'h0000; oneshot = 1'b1; ce = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < 20; r++) begin
      chk("zero_addr", 32'(address), 32'd0);
      chk("zero_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_idle", 32'(busy), 32'd0);

    // Randomized run against the reference model with a scrambled memory.
    for (int i = 0; i < 256; i++) mem[i] = 8'((i * 37 + 11) & 255);
    m_run = 1'b0; m_flush = 0; m_phase = 0; m_step = 0; m_mode = 1'b0;
    m_done_cyc = -1; m_sample = 0; eq.delete();
    for (int c = 0; c < 4000; c++) begin
      exp_v = 1'b0;
      if (eq.size() > 0 && eq[0].cyc == c) begin
        exp_v    = 1'b1;
        m_sample = eq[0].val;
        void'(eq.pop_front());
      end
      if (c >= 1) begin
        chk("rnd_addr", 32'(address), 32'(m_phase >> 8));
        chk("rnd_vld",  32'(sample_valid), 32'(exp_v));
        chk("rnd_smp",  32'(sample), 32'(m_sample));
        chk("rnd_busy", 32'(busy), 32'(m_run || m_flush > 0));
        chk("rnd_done", 32'(done), 32'(m_done_cyc == c));
      end

      rst     = (c < 2) || ($urandom_range(0, 199) == 0);
      start   = ($urandom_range(0, 4) == 0);
      stop    = ($urandom_range(0, 29) == 0);
      oneshot = 1'($urandom_range(0, 1));
      ce      = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 3))
        0:       step = 16'($urandom);
        1:       step = 16'($urandom_range(0, 16'h0FFF));
        2:       step = 16'h0000;
        default: step = 16'h0100;
      endcase

      if (rst) begin
        m_run = 1'b0; m_flush = 0; m_phase = 0; m_step = 0; m_mode = 1'b0;
        m_done_cyc = -1; m_sample = 0; eq.delete();
      end else if (m_flush > 0) begin
        m_flush--;
        if (m_flush == 0) m_done_cyc = c + 1;
      end else if (m_run) begin
        if (stop) begin
          m_run = 1'b0; m_flush = 2;
        end else if (ce) begin
          eq.push_back('{c + 2, int'(mem[m_phase >> 8])});
          m_phase = m_phase + m_step;
          if (m_phase > 32'hFFFF) begin
            m_phase = m_phase & 32'hFFFF;
            if (m_mode) begin
              m_run = 1'b0; m_flush = 2;
            end
          end
        end
      end else if (start && !stop) begin
        m_run = 1'b1; m_phase = 0; m_step = 32'(step); m_mode = oneshot;
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
